// File: rtl/divider_pkg.sv
// Shared ALU-unit definitions: opcodes for the divider/multiplier and the
// common IDLE/RUN/DONE state encoding.
package divider_pkg;

    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_OUT   = 6'b111111;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ITERS  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift {rem, quot} left, trial-subtract
// the divisor and keep the trial when it does not go negative.
module div_step
    import divider_pkg::*;
(
    input  logic [WORD_W:0]   rem,
    input  logic [WORD_W-1:0] quot,
    input  logic [WORD_W-1:0] divisor,
    output logic [WORD_W:0]   rem_next,
    output logic [WORD_W-1:0] quot_next
);

    logic [WORD_W+1:0] shifted;
    logic [WORD_W+1:0] trial;

    always_comb begin
        shifted = {rem, quot[WORD_W-1]};
        trial   = shifted - {2'b00, divisor};
        // Top bit of the widened trial is the borrow: set means the divisor did not fit.
        if (!trial[WORD_W+1]) begin
            rem_next  = trial[WORD_W:0];
            quot_next = {quot[WORD_W-2:0], 1'b1};
        end else begin
            rem_next  = shifted[WORD_W:0];
            quot_next = {quot[WORD_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider.sv
// 32-bit unsigned sequential divider: fixed 32-cycle restoring algorithm with
// a divide-by-zero shortcut, result presented as {remainder, quotient}.
module divider
    import divider_pkg::*;
#(
    parameter logic [5:0] DIVU = OP_DIVU,
    parameter logic [5:0] OUT  = OP_OUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD_W-1:0]   dataA,
    input  logic [WORD_W-1:0]   dataB,
    input  logic [5:0]          Signal,
    output logic [2*WORD_W-1:0] dataOut,
    output logic                busy,
    output logic                done,
    output logic                divZero
);

    state_t            state_reg;
    logic [WORD_W:0]   rem_reg;
    logic [WORD_W-1:0] quot_reg;
    logic [WORD_W-1:0] divisor_reg;
    logic [4:0]        cnt_reg;

    logic [WORD_W:0]   rem_next;
    logic [WORD_W-1:0] quot_next;

    div_step u_step (
        .rem       (rem_reg),
        .quot      (quot_reg),
        .divisor   (divisor_reg),
        .rem_next  (rem_next),
        .quot_next (quot_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            rem_reg     <= '0;
            quot_reg    <= '0;
            divisor_reg <= '0;
            cnt_reg     <= '0;
            dataOut     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            divZero     <= 1'b0;
        end else if (Signal == OUT) begin
            state_reg   <= ST_IDLE;
            rem_reg     <= '0;
            quot_reg    <= '0;
            divisor_reg <= '0;
            cnt_reg     <= '0;
            dataOut     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            divZero     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (Signal == DIVU) begin
                        quot_reg    <= dataA;
                        divisor_reg <= dataB;
                        rem_reg     <= '0;
                        cnt_reg     <= '0;
                        done        <= 1'b0;
                        divZero     <= 1'b0;
                        if (dataB == '0) begin
                            dataOut   <= {dataA, {WORD_W{1'b1}}};
                            done      <= 1'b1;
                            divZero   <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            busy      <= 1'b1;
                            state_reg <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    rem_reg  <= rem_next;
                    quot_reg <= quot_next;
                    cnt_reg  <= cnt_reg + 5'd1;
                    // Counter wraps to 0 after this edge, which is the idle value anyway.
                    if (cnt_reg == 5'(ITERS - 1)) begin
                        dataOut   <= {rem_next[WORD_W-1:0], quot_next};
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    divZero   <= 1'b0;
                end
            endcase
        end
    end

endmodule
